// File: rtl/gpio_io_bridge.sv
// Board-side GPIO peer: debounced switch word in, decimal 7-segment display out.
// Display path uses a 32-step sequential double-dabble converter.
module gpio_io_bridge #(
  parameter int SW_WIDTH        = 18,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SW_WIDTH-1:0] sw_in,
  output logic [31:0]         gpio_in,
  input  logic [31:0]         gpio_out,
  output logic [6:0]          hex0,
  output logic [6:0]          hex1,
  output logic [6:0]          hex2,
  output logic [6:0]          hex3,
  output logic [6:0]          hex4,
  output logic [6:0]          hex5,
  output logic [6:0]          hex6,
  output logic [6:0]          hex7,
  output logic                busy,
  output logic                ovf
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] ZERO  = 7'b1000000;

  logic [SW_WIDTH-1:0] sync1;
  logic [SW_WIDTH-1:0] sync2;
  logic [SW_WIDTH-1:0] cand;
  logic [CW-1:0]       db_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= '0;
      db_cnt  <= '0;
      gpio_in <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand   <= sync2;
        db_cnt <= '0;
      end else begin
        if (db_cnt != CNT_MAX) db_cnt <= db_cnt + 1'b1;
        if (db_cnt == CNT_MAX) gpio_in <= 32'(cand);
      end
    end
  end

  logic [1:0]  state;
  logic [31:0] bin;
  logic [39:0] bcd;
  logic [4:0]  sh_cnt;
  logic [31:0] cap;
  logic [31:0] last_val;
  logic [6:0]  hex_q [8];

  logic [39:0] adj;
  logic [71:0] shifted;

  always_comb begin
    adj = '0;
    for (int i = 0; i < 10; i++) begin
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ?
                      bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
  end

  assign shifted = {adj, bin} << 1;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = BLANK;
    endcase
  endfunction

  logic       ovf_n;
  logic       seen;
  logic [6:0] disp [8];

  // Walk from the top digit down; once a nonzero digit is seen, all below show.
  always_comb begin
    ovf_n = |bcd[39:32];
    seen  = ovf_n;
    for (int i = 7; i >= 0; i--) begin
      seen    = seen | (bcd[4*i +: 4] != 4'd0) | (i == 0);
      disp[i] = seen ? seg(bcd[4*i +: 4]) : BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bin      <= '0;
      bcd      <= '0;
      sh_cnt   <= '0;
      cap      <= '0;
      last_val <= '0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
      hex_q[0] <= ZERO;
      for (int i = 1; i < 8; i++) hex_q[i] <= BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (gpio_out != last_val) begin
            bin    <= gpio_out;
            cap    <= gpio_out;
            bcd    <= '0;
            sh_cnt <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd    <= shifted[71:32];
          bin    <= shifted[31:0];
          sh_cnt <= sh_cnt + 1'b1;
          if (sh_cnt == 5'd31) state <= DONE;
        end
        DONE: begin
          for (int i = 0; i < 8; i++) hex_q[i] <= disp[i];
          last_val <= cap;
          ovf      <= ovf_n;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign hex6 = hex_q[6];
  assign hex7 = hex_q[7];

endmodule

// File: tb/tb_gpio_io_bridge.sv
// Directed bench for gpio_io_bridge: debounce latency, bounce rejection,
// conversion timing, display encoding and mid-conversion corner cases.
module tb_gpio_io_bridge;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] sw_in = '0;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out = '0;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic        busy;
  logic        ovf;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gpio_io_bridge #(.SW_WIDTH(18), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7),
    .busy(busy), .ovf(ovf)
  );

  typedef struct {
    logic [31:0]      val;
    logic [7:0][6:0]  hx;
    logic             ov;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0][6:0] hexes();
    return {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  // Waits at negedges while busy equals lvl; returns cycles spent.
  task automatic wait_while(input logic lvl, output int n);
    n = 0;
    while (busy === lvl && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic conv(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    gpio_out = v.val;
    @(negedge clk);
    wait_while(1'b1, n);
    check({nm, "_busy_cycles"}, 64'(n), 64'd33);
    check({nm, "_hex"}, 64'(hexes()), 64'(v.hx));
    check({nm, "_ovf"}, 64'(ovf), 64'(v.ov));
  endtask

  initial begin
    int n;
    logic early;
    logic seen_busy;
    logic [17:0] tv;

    vt[0] = '{32'd12345678, {S1, S2, S3, S4, S5, S6, S7, S8}, 1'b0};
    vt[1] = '{32'hFFFFFFFF, {S9, S4, S9, S6, S7, S2, S9, S5}, 1'b1};
    vt[2] = '{32'd42,       {BL, BL, BL, BL, BL, BL, S4, S2}, 1'b0};
    vt[3] = '{32'd100000000, {S0, S0, S0, S0, S0, S0, S0, S0}, 1'b1};
    vt[4] = '{32'd99999999, {S9, S9, S9, S9, S9, S9, S9, S9}, 1'b0};
    vt[5] = '{32'd0,        {BL, BL, BL, BL, BL, BL, BL, S0}, 1'b0};
    vt[6] = '{32'd10,       {BL, BL, BL, BL, BL, BL, S1, S0}, 1'b0};
    vt[7] = '{32'd1000000,  {BL, S1, S0, S0, S0, S0, S0, S0}, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_gpio_in", 64'(gpio_in), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_hex", 64'(hexes()), 64'({BL, BL, BL, BL, BL, BL, BL, S0}));
    seen_busy = 1'b0;
    repeat (100) begin
      @(negedge clk);
      seen_busy |= busy;
    end
    check("idle_busy_100", 64'(seen_busy), 64'd0);

    sw_in = 18'h00005;
    early = 1'b0;
    for (int k = 1; k < 19; k++) begin
      @(posedge clk); #1;
      if (gpio_in !== 32'd0) early = 1'b1;
    end
    check("deb_early", 64'(early), 64'd0);
    @(posedge clk); #1;
    check("deb_19", 64'(gpio_in), 64'h5);

    @(negedge clk);
    sw_in = '0;
    repeat (25) @(negedge clk);
    check("deb_back0", 64'(gpio_in), 64'd0);

    early = 1'b0;
    tv = '0;
    for (int t = 0; t < 12; t++) begin
      tv = ~tv;
      sw_in = tv;
      repeat (5) begin
        @(negedge clk);
        if (gpio_in !== 32'd0) early = 1'b1;
      end
    end
    sw_in = 18'h3FFFF;
    for (int k = 1; k < 19; k++) begin
      @(posedge clk); #1;
      if (gpio_in !== 32'd0) early = 1'b1;
    end
    check("bounce_hold0", 64'(early), 64'd0);
    @(posedge clk); #1;
    check("bounce_19", 64'(gpio_in), 64'h3FFFF);

    for (int i = 0; i < 8; i++) conv(vt[i], $sformatf("vec%0d", i));

    seen_busy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen_busy |= busy;
    end
    check("same_val_no_busy", 64'(seen_busy), 64'd0);

    gpio_out = 32'd42;
    repeat (10) @(negedge clk);
    gpio_out = 32'd7;
    wait_while(1'b1, n);
    check("mid_first_42", 64'(hexes()), 64'({BL, BL, BL, BL, BL, BL, S4, S2}));
    @(negedge clk);
    check("mid_reconv_busy", 64'(busy), 64'd1);
    wait_while(1'b1, n);
    check("mid_reconv_cycles", 64'(n), 64'd33);
    check("mid_final_7", 64'(hexes()), 64'({BL, BL, BL, BL, BL, BL, BL, S7}));

    gpio_out = 32'd99;
    repeat (11) @(negedge clk);
    check("rstmid_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_hex", 64'(hexes()), 64'({BL, BL, BL, BL, BL, BL, BL, S0}));
    check("rstmid_ovf", 64'(ovf), 64'd0);
    gpio_out = 32'd7;
    @(negedge clk);
    rst_n = 1'b1;
    wait_while(1'b0, n);
    check("rstmid_restart", 64'(n < 200), 64'd1);
    wait_while(1'b1, n);
    check("rstmid_cycles", 64'(n), 64'd33);
    check("rstmid_hex7", 64'(hexes()), 64'({BL, BL, BL, BL, BL, BL, BL, S7}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
